hram_arbiter: RTL
=================

HRAM_ARBITER -- requirements
Module: hram_arbiter

Interface
REQ-001 Parameter NPORTS, default 2, SHALL set the number of requester ports (2..4).
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the byte address width of every port.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL set the data width.
REQ-004 Parameter MODULES, default 4, SHALL set the number of HyperRAM devices behind the controller.
REQ-005 Parameter RAM_SIZE, default 8388608, SHALL set the per-device size in bytes.
REQ-006 Parameter TIMEOUT, default 1023, SHALL set the maximum WAIT cycles before abort.
REQ-007 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-008 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-009 Ports req_i and we_i, input, NPORTS each: per-port request and write-enable.
REQ-010 Ports addr_i and wdata_i, input, NPORTS*ADDR_WIDTH and NPORTS*DATA_WIDTH: flattened, port p at slice p.
REQ-011 Ports ack_o and err_o, output, NPORTS each: per-port completion pulse and error flag.
REQ-012 Port rdata_o, output, DATA_WIDTH: shared read data, valid while ack_o is high.
REQ-013 Port grant_o, output, NPORTS: one-hot owner; port busy_o, output, 1: high in any non-IDLE state.
REQ-014 Controller side: ctrl_valid_o (1), ctrl_ready_i (1), ctrl_we_o (1), ctrl_addr_o (ADDR_WIDTH), ctrl_wdata_o (DATA_WIDTH), ctrl_done_i (1), ctrl_rdata_i (DATA_WIDTH).

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, WAIT and RESP.
REQ-016 Requesters SHALL hold req_i, we_i, addr_i and wdata_i stable until their ack_o; the block relies on this.
REQ-017 In IDLE with any req_i high, the winner SHALL be the first requesting port at or after rr_ptr, searched upward modulo NPORTS.
REQ-018 On a grant, the winner's we, addr and wdata SHALL be registered and grant_o set one-hot, all on the same edge.
REQ-019 If the granted address has any bit at or above clog2(RAM_SIZE*MODULES) set, the FSM SHALL go IDLE->RESP with err set, and no controller transaction SHALL occur.
REQ-020 Otherwise the FSM SHALL go IDLE->ISSUE, and ctrl_valid_o SHALL be high for the whole ISSUE state, with the registered fields driven on ctrl_*.
REQ-021 ISSUE->WAIT SHALL occur on the edge where ctrl_valid_o and ctrl_ready_i are both high, and ctrl_valid_o SHALL drop in WAIT.
REQ-022 A 16-bit timeout counter SHALL clear on WAIT entry and increment each WAIT cycle.
REQ-023 WAIT->RESP SHALL occur on ctrl_done_i, with ctrl_rdata_i captured and err cleared.
REQ-024 WAIT->RESP SHALL also occur when the counter equals TIMEOUT, with err set and rdata forced to 0.
REQ-025 If ctrl_done_i is high in the same cycle the counter reaches TIMEOUT, done SHALL win and err SHALL be 0.
REQ-026 In RESP, ack_o[g] SHALL pulse for exactly one cycle, with err_o[g] and rdata_o valid in that cycle; all other ack_o/err_o bits SHALL be 0.
REQ-027 On RESP->IDLE, rr_ptr SHALL become (g+1) mod NPORTS and grant_o SHALL clear.
REQ-028 ctrl_done_i SHALL be ignored outside WAIT.
REQ-029 Minimum latency from req_i to ack_o SHALL be 4 cycles: grant, handshake, done, ack, with ctrl_ready_i and ctrl_done_i each high on the first possible cycle.
REQ-030 A port whose req_i is still high after its ack SHALL be treated as a new request.

Reset
REQ-031 While rst is high, the FSM SHALL be IDLE and rr_ptr SHALL be 0, regardless of clk.
REQ-032 While rst is high, all outputs, the registered fields and the counter SHALL be 0.
REQ-033 Reset asserted mid-transaction SHALL abort it without an ack; no ack SHALL be issued for it after reset release.

Verification
REQ-034 Single read: req_i=01, addr 0x0000_0010, ready and done immediate, ctrl_rdata 0xDEADBEEF -> ack_o=01 with rdata_o=0xDEADBEEF 4 cycles after req, err_o=00.
REQ-035 Contention: req_i=11 held from reset -> grants alternate port 0, 1, 0, 1 over four transactions, and rr_ptr=1 after the first.
REQ-036 Out of range: addr 0x0200_0000 (MODULES=4, RAM_SIZE=8 MiB) -> ctrl_valid_o stays 0, ack_o and err_o pulse 2 cycles after req.
REQ-037 Timeout: done never asserted, TIMEOUT=1023 -> err ack after 1023 WAIT cycles, rdata_o=0; a late ctrl_done_i in IDLE is ignored.
REQ-038 Collision: ctrl_done_i on the TIMEOUT cycle -> ack with err=0 and the captured rdata.
REQ-039 Mid-op reset: rst pulsed in WAIT -> all outputs 0 immediately; after release, a new req_i=10 is granted to port 1 from IDLE with rr_ptr=0.

Source files
------------

// File: rtl/hram_arbiter.sv
// hram_arbiter: round-robin arbiter that serialises NPORTS requesters onto one
// HyperRAM controller, with out-of-range rejection and a WAIT timeout.
module hram_arbiter #(
    parameter int NPORTS     = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MODULES    = 4,
    parameter int RAM_SIZE   = 8388608,
    parameter int TIMEOUT    = 1023
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NPORTS-1:0]            req_i,
    input  logic [NPORTS-1:0]            we_i,
    input  logic [NPORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NPORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NPORTS-1:0]            ack_o,
    output logic [NPORTS-1:0]            err_o,
    output logic [DATA_WIDTH-1:0]        rdata_o,
    output logic [NPORTS-1:0]            grant_o,
    output logic                         busy_o,
    output logic                         ctrl_valid_o,
    input  logic                         ctrl_ready_i,
    output logic                         ctrl_we_o,
    output logic [ADDR_WIDTH-1:0]        ctrl_addr_o,
    output logic [DATA_WIDTH-1:0]        ctrl_wdata_o,
    input  logic                         ctrl_done_i,
    input  logic [DATA_WIDTH-1:0]        ctrl_rdata_i
);
    localparam int PW  = $clog2(NPORTS);
    localparam int LIM = $clog2(longint'(RAM_SIZE) * longint'(MODULES));
    // Any address bit at or above LIM lies outside the populated devices.
    localparam logic [ADDR_WIDTH-1:0] HI = {ADDR_WIDTH{1'b1}} << LIM;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t                  state;
    logic [PW-1:0]           rr_ptr;
    logic [PW-1:0]           gidx;
    logic [PW-1:0]           win;
    logic [15:0]             cnt;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [ADDR_WIDTH-1:0]   waddr;
    logic                    oor;

    // Scan downward so the last hit is the nearest requester at or after rr_ptr.
    always_comb begin
        win = '0;
        for (int i = NPORTS - 1; i >= 0; i--)
            if (req_i[(int'(rr_ptr) + i) % NPORTS]) win = PW'((int'(rr_ptr) + i) % NPORTS);
    end

    assign waddr = addr_i[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
    assign oor   = |(waddr & HI);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            gidx         <= '0;
            grant_o      <= '0;
            ctrl_we_o    <= 1'b0;
            ctrl_addr_o  <= '0;
            ctrl_wdata_o <= '0;
            cnt          <= '0;
            err          <= 1'b0;
            rdata        <= '0;
        end else begin
            case (state)
                IDLE: if (|req_i) begin
                    gidx         <= win;
                    grant_o      <= NPORTS'(1) << win;
                    ctrl_we_o    <= we_i[win];
                    ctrl_addr_o  <= waddr;
                    ctrl_wdata_o <= wdata_i[int'(win)*DATA_WIDTH +: DATA_WIDTH];
                    rdata        <= '0;
                    err          <= oor;
                    state        <= oor ? RESP : ISSUE;
                end
                ISSUE: if (ctrl_ready_i) begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 16'd1;
                    if (ctrl_done_i) begin
                        rdata <= ctrl_rdata_i;
                        err   <= 1'b0;
                        state <= RESP;
                    end else if (cnt == 16'(TIMEOUT)) begin
                        rdata <= '0;
                        err   <= 1'b1;
                        state <= RESP;
                    end
                end
                RESP: begin
                    rr_ptr  <= (gidx == PW'(NPORTS - 1)) ? '0 : gidx + 1'b1;
                    grant_o <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o       = state != IDLE;
    assign ctrl_valid_o = state == ISSUE;
    assign ack_o        = (state == RESP) ? grant_o : '0;
    assign err_o        = (state == RESP && err) ? grant_o : '0;
    assign rdata_o      = rdata;
endmodule
